// File: rtl/gumnut_ctrl_fsm.sv
// gumnut_ctrl_fsm -- multi-cycle control unit for the Gumnut core.
// Sequences fetch/decode/execute/memory/writeback, handshakes with instruction
// memory, data memory and I/O ports, and handles interrupts, wait/standby,
// illegal opcodes and an ack watchdog.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   op_i                opcode field of IR (class decode on the top 7 bits)
//   misc_i              misc sub-op (ret/reti/enai/disi/wait/stby)
//   br_taken_i          branch condition, sampled in EXEC
//   imem/dmem/port_ack_i  memory and port acknowledges
//   int_req_i           level interrupt request
//   imem_req_o, ir_we_o, pc_we_o, pc_sel_o   fetch and PC control
//   dmem_req_o, port_req_o, mem_we_o         data/port access control
//   rf_we_o, stk_push_o, stk_pop_o           register file and return stack
//   int_ack_o           interrupt acknowledge pulse
//   ien_o, err_o        interrupt enable and sticky error flags (registered)
//   state_o             current state for debug
// Strobes are decoded from the state register and the current acks so that a
// handshake completes in the ack cycle; they are forced low while rst is high.

module gumnut_ctrl_fsm #(
    parameter int unsigned OP_W    = 7,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TO_W    = 4,
    parameter bit          INT_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] op_i,
    input  logic [2:0]      misc_i,
    input  logic            br_taken_i,
    input  logic            imem_ack_i,
    input  logic            dmem_ack_i,
    input  logic            port_ack_i,
    input  logic            int_req_i,
    output logic            imem_req_o,
    output logic            ir_we_o,
    output logic            pc_we_o,
    output logic [1:0]      pc_sel_o,
    output logic            dmem_req_o,
    output logic            port_req_o,
    output logic            mem_we_o,
    output logic            rf_we_o,
    output logic            stk_push_o,
    output logic            stk_pop_o,
    output logic            int_ack_o,
    output logic            ien_o,
    output logic            err_o,
    output logic [2:0]      state_o
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_INT    = 3'd5,
        ST_WAIT   = 3'd6,
        ST_ERR    = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_MEM,
        CL_JMP,
        CL_JSB,
        CL_BR,
        CL_MISC,
        CL_ILL
    } op_class_e;

    localparam bit              WD_ON   = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            ien_q, ien_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] wd_q, wd_d;

    logic [6:0]      opc;
    op_class_e       cls;
    logic            mem_port;
    logic            mem_wr;
    logic            mem_ack;
    logic            wd_hit;

    logic            imem_req_c, ir_we_c, pc_we_c, dmem_req_c, port_req_c;
    logic            mem_we_c, rf_we_c, stk_push_c, stk_pop_c, int_ack_c;
    logic [1:0]      pc_sel_c;

    assign opc      = op_i[OP_W-1 -: 7];
    assign mem_port = opc[4];
    assign mem_wr   = opc[3];
    assign mem_ack  = mem_port ? port_ack_i : dmem_ack_i;
    assign wd_hit   = WD_ON && (wd_q == WD_LAST);

    // Instruction end: take an interrupt if enabled and requested, else fetch.
    function automatic state_e instr_end(input logic ien, input logic req);
        return (INT_EN && ien && req) ? ST_INT : ST_FETCH;
    endfunction

    // Opcode class decode; shift and both ALU forms share the writeback path.
    always_comb begin
        cls = CL_ILL;
        if (!opc[6])      cls = CL_ALU;
        else if (!opc[5]) cls = CL_MEM;
        else if (!opc[4]) cls = CL_ALU;
        else if (!opc[3]) cls = CL_ALU;
        else if (!opc[2]) cls = opc[1] ? CL_ILL : (opc[0] ? CL_JSB : CL_JMP);
        else if (!opc[1]) cls = CL_BR;
        else if (!opc[0]) cls = (misc_i[2:1] == 2'b11) ? CL_ILL : CL_MISC;
    end

    // Next-state, flag updates and strobe decode.
    always_comb begin
        state_d    = state_q;
        ien_d      = ien_q;
        err_d      = err_q;
        wd_d       = '0;
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = 2'b00;
        dmem_req_c = 1'b0;
        port_req_c = 1'b0;
        mem_we_c   = 1'b0;
        rf_we_c    = 1'b0;
        stk_push_c = 1'b0;
        stk_pop_c  = 1'b0;
        int_ack_c  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack_i) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = ST_DECODE;
                end else if (wd_hit) begin
                    state_d = ST_ERR;
                end else if (WD_ON) begin
                    wd_d = wd_q + TO_W'(1);
                end
            end

            ST_DECODE: begin
                state_d = (cls == CL_ILL) ? ST_ERR : ST_EXEC;
            end

            ST_EXEC: begin
                case (cls)
                    CL_ALU: state_d = ST_WB;
                    CL_MEM: state_d = ST_MEM;
                    CL_JMP, CL_JSB: begin
                        pc_we_c    = 1'b1;
                        pc_sel_c   = 2'b01;
                        stk_push_c = (cls == CL_JSB);
                        state_d    = instr_end(ien_d, int_req_i);
                    end
                    CL_BR: begin
                        if (br_taken_i) begin
                            pc_we_c  = 1'b1;
                            pc_sel_c = 2'b01;
                        end
                        state_d = instr_end(ien_d, int_req_i);
                    end
                    CL_MISC: begin
                        case (misc_i)
                            3'b000: begin
                                stk_pop_c = 1'b1;
                                pc_we_c   = 1'b1;
                                pc_sel_c  = 2'b10;
                            end
                            3'b001: begin
                                stk_pop_c = 1'b1;
                                pc_we_c   = 1'b1;
                                pc_sel_c  = 2'b10;
                                ien_d     = 1'b1;
                            end
                            3'b010:  ien_d = 1'b1;
                            3'b011:  ien_d = 1'b0;
                            default: ;
                        endcase
                        // ien_d already reflects enai/disi/reti for the NEXT check.
                        if (misc_i[2]) state_d = misc_i[1] ? ST_ERR : ST_WAIT;
                        else           state_d = instr_end(ien_d, int_req_i);
                    end
                    default: state_d = ST_ERR;
                endcase
            end

            ST_MEM: begin
                dmem_req_c = !mem_port;
                port_req_c = mem_port;
                mem_we_c   = mem_wr;
                if (mem_ack) begin
                    state_d = mem_wr ? instr_end(ien_q, int_req_i) : ST_WB;
                end else if (wd_hit) begin
                    state_d = ST_ERR;
                end else if (WD_ON) begin
                    wd_d = wd_q + TO_W'(1);
                end
            end

            ST_WB: begin
                rf_we_c = 1'b1;
                state_d = instr_end(ien_q, int_req_i);
            end

            ST_INT: begin
                int_ack_c  = 1'b1;
                stk_push_c = 1'b1;
                pc_we_c    = 1'b1;
                pc_sel_c   = 2'b11;
                ien_d      = 1'b0;
                state_d    = ST_FETCH;
            end

            ST_WAIT: begin
                if (INT_EN && ien_q && int_req_i) state_d = ST_INT;
            end

            default: state_d = ST_ERR;
        endcase

        if (state_d == ST_ERR) err_d = 1'b1;
    end

    // State and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            ien_q   <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ien_q   <= ien_d & INT_EN;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    // Strobes are suppressed the moment rst rises.
    assign imem_req_o = imem_req_c & ~rst;
    assign ir_we_o    = ir_we_c & ~rst;
    assign pc_we_o    = pc_we_c & ~rst;
    assign pc_sel_o   = rst ? 2'b00 : pc_sel_c;
    assign dmem_req_o = dmem_req_c & ~rst;
    assign port_req_o = port_req_c & ~rst;
    assign mem_we_o   = mem_we_c & ~rst;
    assign rf_we_o    = rf_we_c & ~rst;
    assign stk_push_o = stk_push_c & ~rst;
    assign stk_pop_o  = stk_pop_c & ~rst;
    assign int_ack_o  = int_ack_c & ~rst;
    assign ien_o      = ien_q;
    assign err_o      = err_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_gumnut_ctrl_fsm.sv
// Testbench for gumnut_ctrl_fsm: directed vector table, hand sequences for the
// multi-cycle corner cases, and random instruction streams checked against an
// instruction-level model that expands each instruction into its cycle trace.

module tb_gumnut_ctrl_fsm;

    localparam int unsigned OP_W    = 7;
    localparam int unsigned TIMEOUT = 15;

    localparam logic [12:0] S_IMEM = 13'h1000;
    localparam logic [12:0] S_IRWE = 13'h0800;
    localparam logic [12:0] S_PCWE = 13'h0400;
    localparam logic [12:0] SEL_01 = 13'h0100;
    localparam logic [12:0] SEL_10 = 13'h0200;
    localparam logic [12:0] SEL_11 = 13'h0300;
    localparam logic [12:0] S_DMEM = 13'h0080;
    localparam logic [12:0] S_PORT = 13'h0040;
    localparam logic [12:0] S_MWE  = 13'h0020;
    localparam logic [12:0] S_RFWE = 13'h0010;
    localparam logic [12:0] S_PUSH = 13'h0008;
    localparam logic [12:0] S_POP  = 13'h0004;
    localparam logic [12:0] S_IACK = 13'h0002;
    localparam logic [12:0] S_NONE = 13'h0000;
    localparam logic [12:0] S_FET  = S_IMEM | S_IRWE | S_PCWE;
    localparam logic [12:0] S_INTR = S_IACK | S_PUSH | S_PCWE | SEL_11;

    localparam logic [2:0] FE = 3'd0, DE = 3'd1, EX = 3'd2, ME = 3'd3;
    localparam logic [2:0] WB = 3'd4, IN = 3'd5, WT = 3'd6, ER = 3'd7;

    localparam logic [6:0] OP_ALU  = 7'b0000001;
    localparam logic [6:0] OP_LDM  = 7'b1000000;
    localparam logic [6:0] OP_MISC = 7'b1111110;

    logic            clk = 1'b0;
    logic            rst;
    logic [OP_W-1:0] op_i;
    logic [2:0]      misc_i;
    logic            br_taken_i, imem_ack_i, dmem_ack_i, port_ack_i, int_req_i;
    logic            imem_req_o, ir_we_o, pc_we_o, dmem_req_o, port_req_o, mem_we_o;
    logic            rf_we_o, stk_push_o, stk_pop_o, int_ack_o, ien_o, err_o;
    logic [1:0]      pc_sel_o;
    logic [2:0]      state_o;

    gumnut_ctrl_fsm #(.OP_W(OP_W), .TIMEOUT(TIMEOUT), .TO_W(4), .INT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .op_i(op_i), .misc_i(misc_i), .br_taken_i(br_taken_i),
        .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i), .port_ack_i(port_ack_i),
        .int_req_i(int_req_i), .imem_req_o(imem_req_o), .ir_we_o(ir_we_o),
        .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .dmem_req_o(dmem_req_o),
        .port_req_o(port_req_o), .mem_we_o(mem_we_o), .rf_we_o(rf_we_o),
        .stk_push_o(stk_push_o), .stk_pop_o(stk_pop_o), .int_ack_o(int_ack_o),
        .ien_o(ien_o), .err_o(err_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  misc;
        logic        br, iack, dack, pack, ireq;
        logic [2:0]  st;
        logic [12:0] so;
        logic        ien, err;
    } vec_t;

    vec_t q[$];
    int   checks;
    int   errors;
    logic m_ien;

    function automatic vec_t mk(input logic [2:0] st, input logic [12:0] so, input logic ien,
                                input logic err, input logic [6:0] op, input logic [2:0] misc,
                                input logic br, input logic iack, input logic dack,
                                input logic pack, input logic ireq);
        vec_t v;
        v.st = st; v.so = so; v.ien = ien; v.err = err;
        v.op = op; v.misc = misc; v.br = br;
        v.iack = iack; v.dack = dack; v.pack = pack; v.ireq = ireq;
        return v;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic check_now(input logic [2:0] st, input logic [12:0] so, input logic ien,
                             input logic err, input string nm);
        logic [17:0] act, exp;
        act = {state_o, imem_req_o, ir_we_o, pc_we_o, pc_sel_o, dmem_req_o, port_req_o,
               mem_we_o, rf_we_o, stk_push_o, stk_pop_o, int_ack_o, 1'b0, ien_o, err_o};
        exp = {st, so, ien, err};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d out=%h ien=%b err=%b, want st=%0d out=%h ien=%b err=%b",
                     nm, act[17:15], act[14:2], act[1], act[0], st, so, ien, err);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        op_i = v.op; misc_i = v.misc; br_taken_i = v.br;
        imem_ack_i = v.iack; dmem_ack_i = v.dack; port_ack_i = v.pack; int_req_i = v.ireq;
        #2;
        check_now(v.st, v.so, v.ien, v.err, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_q(input string nm);
        vec_t v;
        while (q.size() > 0) begin
            v = q.pop_front();
            apply(v, nm);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        op_i = '0; misc_i = '0; br_taken_i = 1'b0;
        imem_ack_i = 1'b1; dmem_ack_i = 1'b1; port_ack_i = 1'b1; int_req_i = 1'b1;
        @(posedge clk);
        #1;
        check_now(FE, S_NONE, 1'b0, 1'b0, "reset_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ien = 1'b0;
    endtask

    // Expands one instruction into its expected cycle trace from the opcode rules.
    task automatic model_instr(input logic [6:0] op, input logic [2:0] misc, input logic br,
                               input int di, input int dm, input logic ireq);
        logic [12:0] ex, ms;
        logic go_mem, go_wb, new_ien, port, wr;
        ex = S_NONE; go_mem = 1'b0; go_wb = 1'b0; new_ien = m_ien;
        port = op[4]; wr = op[3];
        for (int i = 0; i < di; i++)
            q.push_back(mk(FE, S_IMEM, m_ien, 1'b0, op, misc, br, 1'b0, rb(), rb(), ireq));
        q.push_back(mk(FE, S_FET, m_ien, 1'b0, op, misc, br, 1'b1, rb(), rb(), ireq));
        q.push_back(mk(DE, S_NONE, m_ien, 1'b0, op, misc, br, rb(), rb(), rb(), ireq));
        casez (op)
            7'b0??????, 7'b110????, 7'b1110???: go_wb = 1'b1;
            7'b10?????: go_mem = 1'b1;
            7'b1111000: ex = S_PCWE | SEL_01;
            7'b1111001: ex = S_PCWE | SEL_01 | S_PUSH;
            7'b111110?: ex = br ? (S_PCWE | SEL_01) : S_NONE;
            7'b1111110: begin
                case (misc)
                    3'd0: ex = S_POP | S_PCWE | SEL_10;
                    3'd1: begin ex = S_POP | S_PCWE | SEL_10; new_ien = 1'b1; end
                    3'd2: new_ien = 1'b1;
                    3'd3: new_ien = 1'b0;
                    default: ;
                endcase
            end
            default: ;
        endcase
        q.push_back(mk(EX, ex, m_ien, 1'b0, op, misc, br, rb(), rb(), rb(), ireq));
        m_ien = new_ien;
        if (go_mem) begin
            ms = (port ? S_PORT : S_DMEM) | (wr ? S_MWE : S_NONE);
            for (int i = 0; i < dm; i++)
                q.push_back(mk(ME, ms, m_ien, 1'b0, op, misc, br, rb(),
                               port ? rb() : 1'b0, port ? 1'b0 : rb(), ireq));
            q.push_back(mk(ME, ms, m_ien, 1'b0, op, misc, br, rb(),
                           port ? rb() : 1'b1, port ? 1'b1 : rb(), ireq));
            go_wb = !wr;
        end
        if (go_wb)
            q.push_back(mk(WB, S_RFWE, m_ien, 1'b0, op, misc, br, rb(), rb(), rb(), ireq));
        if (m_ien && ireq) begin
            q.push_back(mk(IN, S_INTR, 1'b1, 1'b0, op, misc, br, rb(), rb(), rb(), ireq));
            m_ien = 1'b0;
        end
    endtask

    initial begin
        vec_t       tbl[26];
        logic [6:0] op;
        logic [6:0] ill_op[3];
        logic [2:0] ill_misc[3];
        logic [2:0] misc;
        int         k;

        checks = 0;
        errors = 0;

        // ALU, delayed ldm, enai + interrupt after WB, enai with immediate interrupt.
        tbl[0]  = mk(FE, S_FET,  0, 0, OP_ALU,  0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(DE, S_NONE, 0, 0, OP_ALU,  0, 0, 0, 1, 1, 0);
        tbl[2]  = mk(EX, S_NONE, 0, 0, OP_ALU,  0, 0, 0, 1, 0, 0);
        tbl[3]  = mk(WB, S_RFWE, 0, 0, OP_ALU,  0, 0, 1, 1, 1, 0);
        tbl[4]  = mk(FE, S_FET,  0, 0, OP_LDM,  0, 0, 1, 0, 0, 0);
        tbl[5]  = mk(DE, S_NONE, 0, 0, OP_LDM,  0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(EX, S_NONE, 0, 0, OP_LDM,  0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(ME, S_DMEM, 0, 0, OP_LDM,  0, 0, 1, 0, 1, 0);
        tbl[8]  = mk(ME, S_DMEM, 0, 0, OP_LDM,  0, 0, 0, 0, 1, 0);
        tbl[9]  = mk(ME, S_DMEM, 0, 0, OP_LDM,  0, 0, 0, 0, 0, 0);
        tbl[10] = mk(ME, S_DMEM, 0, 0, OP_LDM,  0, 0, 0, 1, 0, 0);
        tbl[11] = mk(WB, S_RFWE, 0, 0, OP_LDM,  0, 0, 0, 0, 0, 0);
        tbl[12] = mk(FE, S_FET,  0, 0, OP_MISC, 2, 0, 1, 0, 0, 0);
        tbl[13] = mk(DE, S_NONE, 0, 0, OP_MISC, 2, 0, 0, 0, 0, 0);
        tbl[14] = mk(EX, S_NONE, 0, 0, OP_MISC, 2, 0, 0, 0, 0, 0);
        tbl[15] = mk(FE, S_FET,  1, 0, OP_ALU,  0, 0, 1, 0, 0, 1);
        tbl[16] = mk(DE, S_NONE, 1, 0, OP_ALU,  0, 0, 0, 0, 0, 1);
        tbl[17] = mk(EX, S_NONE, 1, 0, OP_ALU,  0, 0, 0, 0, 0, 1);
        tbl[18] = mk(WB, S_RFWE, 1, 0, OP_ALU,  0, 0, 0, 0, 0, 1);
        tbl[19] = mk(IN, S_INTR, 1, 0, OP_ALU,  0, 0, 1, 1, 1, 1);
        tbl[20] = mk(FE, S_IMEM, 0, 0, OP_ALU,  0, 0, 0, 1, 1, 1);
        tbl[21] = mk(FE, S_FET,  0, 0, OP_MISC, 2, 0, 1, 0, 0, 1);
        tbl[22] = mk(DE, S_NONE, 0, 0, OP_MISC, 2, 0, 0, 0, 0, 1);
        tbl[23] = mk(EX, S_NONE, 0, 0, OP_MISC, 2, 0, 0, 0, 0, 1);
        tbl[24] = mk(IN, S_INTR, 1, 0, OP_MISC, 2, 0, 0, 0, 0, 1);
        tbl[25] = mk(FE, S_IMEM, 0, 0, OP_ALU,  0, 0, 0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 26; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Reset while a load is waiting on data memory.
        do_reset();
        apply(mk(FE, S_FET,  0, 0, OP_MISC, 2, 0, 1, 0, 0, 0), "rstmem_f0");
        apply(mk(DE, S_NONE, 0, 0, OP_MISC, 2, 0, 0, 0, 0, 0), "rstmem_d0");
        apply(mk(EX, S_NONE, 0, 0, OP_MISC, 2, 0, 0, 0, 0, 0), "rstmem_e0");
        apply(mk(FE, S_FET,  1, 0, OP_LDM,  0, 0, 1, 0, 0, 0), "rstmem_f1");
        apply(mk(DE, S_NONE, 1, 0, OP_LDM,  0, 0, 0, 0, 0, 0), "rstmem_d1");
        apply(mk(EX, S_NONE, 1, 0, OP_LDM,  0, 0, 0, 0, 0, 0), "rstmem_e1");
        apply(mk(ME, S_DMEM, 1, 0, OP_LDM,  0, 0, 0, 0, 0, 0), "rstmem_m1");
        #2;
        check_now(ME, S_DMEM, 1'b1, 1'b0, "rstmem_pre");
        rst = 1'b1;
        #1;
        check_now(FE, S_NONE, 1'b0, 1'b0, "rstmem_abort");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Illegal opcode, illegal jump form and illegal misc sub-op lock into ERR.
        ill_op[0] = 7'b1111111; ill_misc[0] = 3'd0;
        ill_op[1] = 7'b1111010; ill_misc[1] = 3'd0;
        ill_op[2] = OP_MISC;    ill_misc[2] = 3'd6;
        for (int n = 0; n < 3; n++) begin
            do_reset();
            apply(mk(FE, S_FET,  0, 0, ill_op[n], ill_misc[n], 0, 1, 0, 0, 0), "ill_fetch");
            apply(mk(DE, S_NONE, 0, 0, ill_op[n], ill_misc[n], 0, 0, 0, 0, 0), "ill_decode");
            for (int i = 0; i < 8; i++)
                apply(mk(ER, S_NONE, 0, 1, ill_op[n], ill_misc[n], rb(), rb(), rb(), rb(), rb()),
                      $sformatf("ill%0d_err%0d", n, i));
        end

        // Fetch watchdog expiry, then an ack landing on the last allowed cycle.
        do_reset();
        for (int i = 0; i < 15; i++)
            apply(mk(FE, S_IMEM, 0, 0, OP_ALU, 0, 0, 0, rb(), rb(), 0), $sformatf("wdf_wait%0d", i));
        for (int i = 0; i < 3; i++)
            apply(mk(ER, S_NONE, 0, 1, OP_ALU, 0, 0, rb(), rb(), rb(), 0), "wdf_err");
        do_reset();
        for (int i = 0; i < 14; i++)
            apply(mk(FE, S_IMEM, 0, 0, OP_ALU, 0, 0, 0, 0, 0, 0), "wdf_ok_wait");
        apply(mk(FE, S_FET,  0, 0, OP_ALU, 0, 0, 1, 0, 0, 0), "wdf_ok_ack");
        apply(mk(DE, S_NONE, 0, 0, OP_ALU, 0, 0, 0, 0, 0, 0), "wdf_ok_decode");

        // Data memory watchdog expiry.
        do_reset();
        apply(mk(FE, S_FET,  0, 0, OP_LDM, 0, 0, 1, 0, 0, 0), "wdm_f");
        apply(mk(DE, S_NONE, 0, 0, OP_LDM, 0, 0, 0, 0, 0, 0), "wdm_d");
        apply(mk(EX, S_NONE, 0, 0, OP_LDM, 0, 0, 0, 0, 0, 0), "wdm_e");
        for (int i = 0; i < 15; i++)
            apply(mk(ME, S_DMEM, 0, 0, OP_LDM, 0, 0, rb(), 0, rb(), 0), $sformatf("wdm_wait%0d", i));
        apply(mk(ER, S_NONE, 0, 1, OP_LDM, 0, 0, 0, 1, 0, 0), "wdm_err");

        // wait with interrupts enabled wakes on request; stby with them disabled never leaves.
        do_reset();
        apply(mk(FE, S_FET,  0, 0, OP_MISC, 2, 0, 1, 0, 0, 0), "wt_f0");
        apply(mk(DE, S_NONE, 0, 0, OP_MISC, 2, 0, 0, 0, 0, 0), "wt_d0");
        apply(mk(EX, S_NONE, 0, 0, OP_MISC, 2, 0, 0, 0, 0, 0), "wt_e0");
        apply(mk(FE, S_FET,  1, 0, OP_MISC, 4, 0, 1, 0, 0, 0), "wt_f1");
        apply(mk(DE, S_NONE, 1, 0, OP_MISC, 4, 0, 0, 0, 0, 0), "wt_d1");
        apply(mk(EX, S_NONE, 1, 0, OP_MISC, 4, 0, 0, 0, 0, 0), "wt_e1");
        for (int i = 0; i < 4; i++)
            apply(mk(WT, S_NONE, 1, 0, OP_MISC, 4, 0, rb(), rb(), rb(), 0), "wt_idle");
        apply(mk(WT, S_NONE, 1, 0, OP_MISC, 4, 0, 0, 0, 0, 1), "wt_wake");
        apply(mk(IN, S_INTR, 1, 0, OP_MISC, 4, 0, 0, 0, 0, 1), "wt_int");
        apply(mk(FE, S_FET,  0, 0, OP_MISC, 5, 0, 1, 0, 0, 1), "sb_f");
        apply(mk(DE, S_NONE, 0, 0, OP_MISC, 5, 0, 0, 0, 0, 1), "sb_d");
        apply(mk(EX, S_NONE, 0, 0, OP_MISC, 5, 0, 0, 0, 0, 1), "sb_e");
        for (int i = 0; i < 20; i++)
            apply(mk(WT, S_NONE, 0, 0, OP_MISC, 5, 0, rb(), rb(), rb(), 1), $sformatf("sb_hold%0d", i));

        // Random legal instruction streams against the instruction-level model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            k = int'($urandom_range(0, 7));
            case (k)
                0:       op = {1'b0, 6'($urandom)};
                1, 7:    op = {2'b10, 5'($urandom)};
                2:       op = {3'b110, 4'($urandom)};
                3:       op = {4'b1110, 3'($urandom)};
                4:       op = {6'b111100, 1'($urandom)};
                5:       op = {6'b111110, 1'($urandom)};
                default: op = OP_MISC;
            endcase
            misc = (op == OP_MISC) ? 3'($urandom_range(0, 3)) : 3'($urandom);
            model_instr(op, misc, rb(), int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                        ($urandom_range(0, 2) == 0));
            apply_q($sformatf("rnd%0d_op%b", n, op));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
